// File: rtl/shift_pkg.sv
// Shared types and field bounds for the multicycle shifter and its
// shift-amount source mux.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    SRC_OFFSET = 2'b00,
    SRC_CONST  = 2'b01,
    SRC_REGB   = 2'b10,
    SRC_IMM    = 2'b11
  } shamt_src_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int OFFSET_HI = 10;
  localparam int OFFSET_LO = 6;

endpackage

// File: rtl/shamt_sel.sv
// Four-way shift-amount source mux; every source is zero-extended or
// truncated to SHAMT_W bits, which takes the amount modulo WIDTH.
module shamt_sel
  import shift_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int CONST_SHAMT = 16,
  localparam int SHAMT_W     = $clog2(WIDTH)
) (
  input  logic [1:0]         sel,
  input  logic [15:0]        offset,
  input  logic [WIDTH-1:0]   regb,
  input  logic [SHAMT_W-1:0] imm,
  output logic [SHAMT_W-1:0] shamt
);

  localparam int FIELD_W = OFFSET_HI - OFFSET_LO + 1;

  logic [FIELD_W-1:0] off_field;
  logic               unused_bits;

  assign off_field   = offset[OFFSET_HI:OFFSET_LO];
  assign unused_bits = ^{offset, regb};

  always_comb begin
    // NOTE: default first so every path assigns shamt and no latch is inferred.
    shamt = '0;
    case (shamt_src_t'(sel))
      SRC_OFFSET: shamt = SHAMT_W'(off_field);
      SRC_CONST:  shamt = SHAMT_W'(CONST_SHAMT);
      SRC_REGB:   shamt = regb[SHAMT_W-1:0];
      SRC_IMM:    shamt = imm;
      default:    shamt = '0;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multicycle SLL/SRL/SRA/ROR shifter moving STEP bits per clock under a
// start/busy/done handshake; result holds until the next accepted start.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int STEP        = 1,
  parameter  int CONST_SHAMT = 16,
  localparam int SHAMT_W     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         shamt_src,
  input  logic [1:0]         shift_op,
  input  logic [15:0]        OFFSET,
  input  logic [WIDTH-1:0]   RegB_out,
  input  logic [SHAMT_W-1:0] shamt_imm,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  // Only used when cnt exceeds STEP, which implies STEP < WIDTH.
  localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP);

  state_t             state_q, state_d;
  shift_op_t          op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] s, s_inv;

  shamt_sel #(
    .WIDTH       (WIDTH),
    .CONST_SHAMT (CONST_SHAMT)
  ) u_shamt_sel (
    .sel    (shamt_src),
    .offset (OFFSET),
    .regb   (RegB_out),
    .imm    (shamt_imm),
    .shamt  (shamt)
  );

  // s is in 1..WIDTH-1 whenever it is used, so WIDTH-s (= -s mod WIDTH) is never 0.
  assign s     = (int'(cnt_q) > STEP) ? STEP_S : cnt_q;
  assign s_inv = '0 - s;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = operand;
          cnt_d    = shamt;
          op_d     = shift_op_t'(shift_op);
          sign_d   = operand[WIDTH-1];
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - s;
          case (op_q)
            OP_SLL:  result_d = result_q << s;
            OP_SRL:  result_d = result_q >> s;
            OP_SRA:  result_d = (result_q >> s) | ({WIDTH{sign_q}} << s_inv);
            OP_ROR:  result_d = (result_q >> s) | (result_q << s_inv);
            default: result_d = result_q;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      result_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: a STEP=1 and a STEP=4 instance share
// data inputs; monitors pop expected result and done cycle on every done.
module tb_shift_unit_seq;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [1:0]  shamt_src = 2'b00;
  logic [1:0]  shift_op = 2'b00;
  logic [15:0] offset = '0;
  logic [31:0] regb = '0;
  logic [4:0]  shamt_imm = '0;
  logic [31:0] operand = '0;
  logic [31:0] result1, result4;
  logic        busy1, busy4, done1, done4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_seq #(.WIDTH(32), .STEP(1), .CONST_SHAMT(16)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .shamt_src(shamt_src),
    .shift_op(shift_op), .OFFSET(offset), .RegB_out(regb),
    .shamt_imm(shamt_imm), .operand(operand), .result(result1),
    .busy(busy1), .done(done1)
  );

  shift_unit_seq #(.WIDTH(32), .STEP(4), .CONST_SHAMT(16)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .shamt_src(shamt_src),
    .shift_op(shift_op), .OFFSET(offset), .RegB_out(regb),
    .shamt_imm(shamt_imm), .operand(operand), .result(result4),
    .busy(busy4), .done(done4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", done1, 1'b0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_result", result1, e1.res);
        check("dut1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", done4, 1'b0);
      end else begin
        e4 = q4.pop_front();
        check("dut4_result", result4, e4.res);
        check("dut4_done_cycle", cyc, e4.cyc);
      end
    end
  end

  // Called at a falling edge; returns just after the accepting edge E0.
  task automatic issue(input bit to4, input logic [1:0] src, input logic [1:0] op,
                       input logic [15:0] off, input logic [31:0] rb,
                       input logic [4:0] imm, input logic [31:0] opnd,
                       input logic [31:0] exp_res, input int n, input bit push);
    exp_t e;
    shamt_src = src;
    shift_op  = op;
    offset    = off;
    regb      = rb;
    shamt_imm = imm;
    operand   = opnd;
    if (to4) start4 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    e.res = exp_res;
    e.cyc = cyc + n + 1;
    if (push) begin
      if (to4) q4.push_back(e);
      else     q1.push_back(e);
    end
  endtask

  task automatic wait_done1(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done1;
    end
  endtask

  task automatic drain();
    bit timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("drain_timeout", timed_out, 1'b0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result1, 32'h0);
    check("reset_busy", busy1, 1'b0);
    check("reset_done", done1, 1'b0);
    check("reset_result4", result4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // SLL via RegB (0x24 truncates to k=4), STEP=1: done after E5
    issue(0, 2'b10, 2'b00, 16'h0, 32'h0000_0024, 5'd0, 32'h0000_0001, 32'h0000_0010, 4, 1);
    check("sll_busy_after_accept", busy1, 1'b1);
    drain();

    // SRA and SRL by CONST_SHAMT=16
    @(negedge clk);
    issue(0, 2'b01, 2'b10, 16'h0, 32'h0, 5'd0, 32'h8000_F000, 32'hFFFF_8000, 16, 1);
    drain();
    issue(0, 2'b01, 2'b01, 16'h0, 32'h0, 5'd0, 32'h8000_F000, 32'h0000_8000, 16, 1);
    drain();

    // ROR by OFFSET[10:6]=8 on STEP=4, in parallel with a STEP=1 copy
    issue(1, 2'b00, 2'b11, 16'h0200, 32'h0, 5'd0, 32'h1234_5678, 32'h7812_3456, 2, 1);
    @(negedge clk);
    issue(0, 2'b00, 2'b11, 16'h0200, 32'h0, 5'd0, 32'h1234_5678, 32'h7812_3456, 8, 1);
    drain();

    // STEP=4 with partial last step (k=5 -> 4+1) and k=0
    issue(1, 2'b11, 2'b00, 16'h0, 32'h0, 5'd5, 32'h0000_0001, 32'h0000_0020, 2, 1);
    drain();
    issue(1, 2'b11, 2'b10, 16'h0, 32'h0, 5'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1);
    drain();

    // k=0 on STEP=1: done after E1, result = operand
    issue(0, 2'b11, 2'b01, 16'h0, 32'h0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
    drain();

    // k=31 SLL with an ignored start mid-operation
    issue(0, 2'b11, 2'b00, 16'h0, 32'h0, 5'd31, 32'h0000_0003, 32'h8000_0000, 31, 1);
    repeat (3) @(negedge clk);
    operand   = 32'hFFFF_FFFF;
    shamt_imm = 5'd1;
    start1    = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("midop_still_busy", busy1, 1'b1);
    drain();

    // Back-to-back: second start in the done cycle of the first
    issue(0, 2'b00, 2'b01, 16'h00C0, 32'h0, 5'd0, 32'h0000_00F0, 32'h0000_001E, 3, 1);
    wait_done1(seen);
    check("b2b_first_done_seen", seen, 1'b1);
    check("b2b_busy_in_done_cycle", busy1, 1'b0);
    issue(0, 2'b11, 2'b11, 16'h0, 32'h0, 5'd4, 32'h0000_000F, 32'hF000_0000, 4, 1);
    check("b2b_busy_after_accept", busy1, 1'b1);
    drain();

    // Reset at cycle 3 of a k=31 SRA aborts it; no done afterwards
    issue(0, 2'b11, 2'b10, 16'h0, 32'h0, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy1, 1'b0);
    check("abort_done", done1, 1'b0);
    check("abort_result", result1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done_pending", busy1, 1'b0);
    check("q1_empty", q1.size(), 0);
    check("q4_empty", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
